ddfs_phase_accumulator: RTL and testbench

- Upstream phase generator for the lock-in DDFS.
- Holds a programmable frequency tuning word (FTW) and advances a wide phase accumulator once per sample tick.
- Presents the top LUT_DEPTH bits as the sine/cosine LUT read address.
- Emits a data-valid strobe aligned to the LUT's 1-cycle synchronous read, so the downstream mixer knows when sine/cosine samples are fresh.
- FTW updates use a valid/ready handshake and are optionally deferred to a phase wrap, keeping reference frequency changes phase-continuous.

---
 rtl/ddfs_phase_accumulator.sv | 121 ++++++++++++
 tb/tb_ddfs_phase_accumulator.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddfs_phase_accumulator.sv
// Phase accumulator for the lock-in DDFS: advances phase by the active tuning word on each
// sample tick, drives the sine/cosine LUT address and tracks the LUT's one-cycle read latency.
module ddfs_phase_accumulator #(
  parameter int ACC_WIDTH   = 32,
  parameter int LUT_DEPTH   = 10,
  parameter int SYNC_UPDATE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 sample_tick,
  input  logic                 phase_clear,
  input  logic [ACC_WIDTH-1:0] ftw_in,
  input  logic                 ftw_valid,
  output logic                 ftw_ready,
  output logic [ACC_WIDTH-1:0] ftw_active,
  output logic [LUT_DEPTH-1:0] addr_out,
  output logic                 addr_valid,
  output logic                 lut_data_valid,
  output logic                 wrap_pulse
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] ftw_active_q, ftw_active_d;
  logic [ACC_WIDTH-1:0] ftw_pend_q, ftw_pend_d;
  logic [LUT_DEPTH-1:0] addr_q, addr_d;
  logic                 addr_valid_q, addr_valid_d;
  logic                 lut_data_valid_q, lut_data_valid_d;
  logic                 wrap_q, wrap_d;

  logic [ACC_WIDTH:0]   sum;
  logic                 accept;
  logic                 defer;

  assign sum    = {1'b0, acc_q} + {1'b0, ftw_active_q};
  assign accept = ftw_valid && ftw_ready;
  // Deferring only matters while running on a nonzero word; otherwise there is no phase to keep.
  assign defer  = (SYNC_UPDATE != 0) && enable && (ftw_active_q != '0);

  always_comb begin
    state_d          = state_q;
    acc_d            = acc_q;
    ftw_active_d     = ftw_active_q;
    ftw_pend_d       = ftw_pend_q;
    addr_d           = addr_q;
    addr_valid_d     = 1'b0;
    wrap_d           = 1'b0;
    lut_data_valid_d = addr_valid_q;

    if (!enable) begin
      state_d = ST_IDLE;
      if (state_q == ST_PEND) ftw_active_d = ftw_pend_q;
      if (phase_clear) acc_d = '0;
    end else begin
      state_d = (state_q == ST_PEND) ? ST_PEND : ST_RUN;
      if (phase_clear) begin
        acc_d = '0;
        if (state_q == ST_PEND) begin
          ftw_active_d = ftw_pend_q;
          state_d      = ST_RUN;
        end
      end else if (sample_tick) begin
        addr_d       = acc_q[ACC_WIDTH-1 -: LUT_DEPTH];
        acc_d        = sum[ACC_WIDTH-1:0];
        addr_valid_d = 1'b1;
        wrap_d       = sum[ACC_WIDTH];
        if (state_q == ST_PEND && sum[ACC_WIDTH]) begin
          ftw_active_d = ftw_pend_q;
          state_d      = ST_RUN;
        end
      end
    end

    // accept is impossible in PEND, so this never collides with a pending release.
    if (accept) begin
      if (defer) begin
        ftw_pend_d = ftw_in;
        state_d    = ST_PEND;
      end else begin
        ftw_active_d = ftw_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      acc_q            <= '0;
      ftw_active_q     <= '0;
      ftw_pend_q       <= '0;
      addr_q           <= '0;
      addr_valid_q     <= 1'b0;
      lut_data_valid_q <= 1'b0;
      wrap_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      acc_q            <= acc_d;
      ftw_active_q     <= ftw_active_d;
      ftw_pend_q       <= ftw_pend_d;
      addr_q           <= addr_d;
      addr_valid_q     <= addr_valid_d;
      lut_data_valid_q <= lut_data_valid_d;
      wrap_q           <= wrap_d;
    end
  end

  assign ftw_ready      = (state_q != ST_PEND);
  assign ftw_active     = ftw_active_q;
  assign addr_out       = addr_q;
  assign addr_valid     = addr_valid_q;
  assign lut_data_valid = lut_data_valid_q;
  assign wrap_pulse     = wrap_q;

endmodule

// File: tb/tb_ddfs_phase_accumulator.sv
// Directed bench for ddfs_phase_accumulator (defaults: 32-bit phase, 10-bit address, deferred FTW).
module tb_ddfs_phase_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        sample_tick;
  logic        phase_clear;
  logic [31:0] ftw_in;
  logic        ftw_valid;
  logic        ftw_ready;
  logic [31:0] ftw_active;
  logic [9:0]  addr_out;
  logic        addr_valid;
  logic        lut_data_valid;
  logic        wrap_pulse;

  int checks = 0;
  int errors = 0;

  ddfs_phase_accumulator #(
    .ACC_WIDTH  (32),
    .LUT_DEPTH  (10),
    .SYNC_UPDATE(1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .sample_tick   (sample_tick),
    .phase_clear   (phase_clear),
    .ftw_in        (ftw_in),
    .ftw_valid     (ftw_valid),
    .ftw_ready     (ftw_ready),
    .ftw_active    (ftw_active),
    .addr_out      (addr_out),
    .addr_valid    (addr_valid),
    .lut_data_valid(lut_data_valid),
    .wrap_pulse    (wrap_pulse)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle 1ns past the rising edge before anything is sampled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    sample_tick = 1'b0;
    phase_clear = 1'b0;
    ftw_valid   = 1'b0;
    ftw_in      = 32'h0;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    enable = 1'b0;
    idle_inputs();
    step();
    step();
    checks++;
    if (addr_out !== 10'd0 || addr_valid !== 1'b0 || lut_data_valid !== 1'b0 ||
        wrap_pulse !== 1'b0 || ftw_ready !== 1'b1 || ftw_active !== 32'h0) begin
      errors++;
      $display("FAIL reset: addr=%0d av=%b ldv=%b wrap=%b rdy=%b ftw=%h, required 0 0 0 0 1 0",
               addr_out, addr_valid, lut_data_valid, wrap_pulse, ftw_ready, ftw_active);
    end
    $display("reset: addr=%0d ready=%b ftw_active=%h", addr_out, ftw_ready, ftw_active);
  endtask

  task automatic test_basic_step();
    rst_n     = 1'b1;
    enable    = 1'b1;
    ftw_in    = 32'h0040_0000;
    ftw_valid = 1'b1;
    step();
    ftw_valid = 1'b0;
    checks++;
    if (ftw_active !== 32'h0040_0000 || ftw_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_load: ftw=%h rdy=%b, required 00400000 1", ftw_active, ftw_ready);
    end
    for (int i = 0; i < 5; i++) begin
      sample_tick = 1'b1;
      step();
      checks++;
      if (addr_valid !== 1'b1 || addr_out !== 10'(i) || wrap_pulse !== 1'b0 || lut_data_valid !== 1'b0) begin
        errors++;
        $display("FAIL basic_tick%0d: av=%b addr=%0d wrap=%b ldv=%b, required 1 %0d 0 0",
                 i, addr_valid, addr_out, wrap_pulse, lut_data_valid, i);
      end
      sample_tick = 1'b0;
      step();
      checks++;
      if (addr_valid !== 1'b0 || lut_data_valid !== 1'b1) begin
        errors++;
        $display("FAIL basic_ldv%0d: av=%b ldv=%b, required 0 1", i, addr_valid, lut_data_valid);
      end
      $display("basic tick %0d: addr=%0d", i, addr_out);
    end
  endtask

  task automatic test_half_rate();
    logic [9:0] exp_addr [4];
    logic       exp_wrap [4];
    exp_addr = '{10'd0, 10'd512, 10'd0, 10'd512};
    exp_wrap = '{1'b0, 1'b1, 1'b0, 1'b1};
    // Load while disabled so the word applies immediately, clearing phase at the same time.
    enable      = 1'b0;
    phase_clear = 1'b1;
    ftw_in      = 32'h8000_0000;
    ftw_valid   = 1'b1;
    step();
    idle_inputs();
    enable = 1'b1;
    checks++;
    if (ftw_active !== 32'h8000_0000 || ftw_ready !== 1'b1) begin
      errors++;
      $display("FAIL half_load: ftw=%h rdy=%b, required 80000000 1", ftw_active, ftw_ready);
    end
    for (int i = 0; i < 4; i++) begin
      sample_tick = 1'b1;
      step();
      checks++;
      if (addr_valid !== 1'b1 || addr_out !== exp_addr[i] || wrap_pulse !== exp_wrap[i] ||
          lut_data_valid !== (i > 0)) begin
        errors++;
        $display("FAIL half_tick%0d: av=%b addr=%0d wrap=%b ldv=%b, required 1 %0d %b %b",
                 i, addr_valid, addr_out, wrap_pulse, lut_data_valid, exp_addr[i], exp_wrap[i], i > 0);
      end
      $display("half tick %0d: addr=%0d wrap=%b", i, addr_out, wrap_pulse);
    end
    sample_tick = 1'b0;
    step();
    checks++;
    if (addr_valid !== 1'b0 || lut_data_valid !== 1'b1 || wrap_pulse !== 1'b0) begin
      errors++;
      $display("FAIL half_tail: av=%b ldv=%b wrap=%b, required 0 1 0", addr_valid, lut_data_valid, wrap_pulse);
    end
  endtask

  task automatic test_sync_update();
    logic [9:0] exp_addr [6];
    logic       exp_wrap [6];
    logic [31:0] exp_ftw [6];
    logic       exp_rdy [6];
    exp_addr = '{10'd256, 10'd512, 10'd768, 10'd0, 10'd1, 10'd2};
    exp_wrap = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_ftw  = '{32'h4000_0000, 32'h4000_0000, 32'h0040_0000,
                 32'h0040_0000, 32'h0040_0000, 32'h0040_0000};
    exp_rdy  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    enable      = 1'b0;
    phase_clear = 1'b1;
    ftw_in      = 32'h4000_0000;
    ftw_valid   = 1'b1;
    step();
    idle_inputs();
    enable      = 1'b1;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    checks++;
    if (addr_out !== 10'd0 || ftw_active !== 32'h4000_0000) begin
      errors++;
      $display("FAIL sync_first: addr=%0d ftw=%h, required 0 40000000", addr_out, ftw_active);
    end
    ftw_in    = 32'h0040_0000;
    ftw_valid = 1'b1;
    step();
    checks++;
    if (ftw_ready !== 1'b0 || ftw_active !== 32'h4000_0000) begin
      errors++;
      $display("FAIL sync_defer: rdy=%b ftw=%h, required 0 40000000", ftw_ready, ftw_active);
    end
    // An offer held during PEND must be refused; it is withdrawn before the wrapping tick.
    ftw_in = 32'h1234_5678;
    for (int i = 0; i < 6; i++) begin
      ftw_valid   = (i < 2);
      sample_tick = 1'b1;
      step();
      checks++;
      if (addr_valid !== 1'b1 || addr_out !== exp_addr[i] || wrap_pulse !== exp_wrap[i] ||
          ftw_active !== exp_ftw[i] || ftw_ready !== exp_rdy[i]) begin
        errors++;
        $display("FAIL sync_tick%0d: av=%b addr=%0d wrap=%b ftw=%h rdy=%b, required 1 %0d %b %h %b",
                 i, addr_valid, addr_out, wrap_pulse, ftw_active, ftw_ready,
                 exp_addr[i], exp_wrap[i], exp_ftw[i], exp_rdy[i]);
      end
      $display("sync tick %0d: addr=%0d wrap=%b ftw_active=%h", i, addr_out, wrap_pulse, ftw_active);
    end
    idle_inputs();
  endtask

  task automatic test_clear_priority();
    enable      = 1'b0;
    phase_clear = 1'b1;
    ftw_in      = 32'h1234_5678;
    ftw_valid   = 1'b1;
    step();
    idle_inputs();
    enable      = 1'b1;
    sample_tick = 1'b1;
    step();
    phase_clear = 1'b1;
    step();
    checks++;
    if (addr_valid !== 1'b0 || wrap_pulse !== 1'b0) begin
      errors++;
      $display("FAIL clear_prio: av=%b wrap=%b, required 0 0", addr_valid, wrap_pulse);
    end
    phase_clear = 1'b0;
    step();
    checks++;
    if (addr_valid !== 1'b1 || addr_out !== 10'd0) begin
      errors++;
      $display("FAIL clear_next: av=%b addr=%0d, required 1 0", addr_valid, addr_out);
    end
    $display("clear priority: addr after clear=%0d", addr_out);
    sample_tick = 1'b0;
    step();
  endtask

  task automatic test_idle();
    rst_n = 1'b0;
    idle_inputs();
    step();
    rst_n     = 1'b1;
    enable    = 1'b0;
    ftw_in    = 32'h0040_0000;
    ftw_valid = 1'b1;
    step();
    ftw_valid = 1'b0;
    checks++;
    if (ftw_active !== 32'h0040_0000 || ftw_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_load: ftw=%h rdy=%b, required 00400000 1", ftw_active, ftw_ready);
    end
    for (int i = 0; i < 3; i++) begin
      sample_tick = 1'b1;
      step();
      checks++;
      if (addr_valid !== 1'b0) begin
        errors++;
        $display("FAIL idle_tick%0d: av=%b, required 0", i, addr_valid);
      end
    end
    enable = 1'b1;
    step();
    checks++;
    if (addr_valid !== 1'b1 || addr_out !== 10'd0) begin
      errors++;
      $display("FAIL idle_held: av=%b addr=%0d, required 1 0", addr_valid, addr_out);
    end
    $display("idle: first run addr=%0d", addr_out);
    sample_tick = 1'b0;
  endtask

  task automatic test_reset_pend();
    ftw_in    = 32'h8000_0000;
    ftw_valid = 1'b1;
    step();
    ftw_valid = 1'b0;
    checks++;
    if (ftw_ready !== 1'b0 || ftw_active !== 32'h0040_0000) begin
      errors++;
      $display("FAIL rpend_enter: rdy=%b ftw=%h, required 0 00400000", ftw_ready, ftw_active);
    end
    sample_tick = 1'b1;
    step();
    checks++;
    if (addr_valid !== 1'b1 || addr_out !== 10'd1) begin
      errors++;
      $display("FAIL rpend_tick: av=%b addr=%0d, required 1 1", addr_valid, addr_out);
    end
    rst_n = 1'b0;
    step();
    checks++;
    if (ftw_active !== 32'h0 || ftw_ready !== 1'b1 || addr_valid !== 1'b0 || lut_data_valid !== 1'b0 ||
        wrap_pulse !== 1'b0 || addr_out !== 10'd0) begin
      errors++;
      $display("FAIL rpend_reset: ftw=%h rdy=%b av=%b ldv=%b wrap=%b addr=%0d, required 0 1 0 0 0 0",
               ftw_active, ftw_ready, addr_valid, lut_data_valid, wrap_pulse, addr_out);
    end
    rst_n = 1'b1;
    step();
    step();
    checks++;
    if (ftw_active !== 32'h0 || ftw_ready !== 1'b1) begin
      errors++;
      $display("FAIL rpend_discard: ftw=%h rdy=%b, required 0 1", ftw_active, ftw_ready);
    end
    $display("reset in pend: ftw_active=%h ready=%b", ftw_active, ftw_ready);
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_basic_step();
    test_half_rate();
    test_sync_update();
    test_clear_priority();
    test_idle();
    test_reset_pend();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
